// File: rtl/gtfmac_hwchk_bitslip_ctrl_pkg.sv
// Shared state encodings and widths for the hwchk bitslip supervisory sequencer.
package gtfmac_hwchk_bitslip_ctrl_pkg;

  localparam int unsigned TIMER_W    = 24;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned RETRY_W    = 4;
  localparam int unsigned LOSS_CNT_W = 16;
  localparam int unsigned FILT_W     = TIMER_W;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    RESET_BS  = 3'd1,
    WAIT_LOCK = 3'd2,
    CORRECT   = 3'd3,
    VERIFY    = 3'd4,
    LINK_UP   = 3'd5,
    FAIL      = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/example_gtfmac_hwchk_bitlip_syncer_level.sv
// Three-flop level synchronizer for quasi-static control inputs.
module example_gtfmac_hwchk_bitlip_syncer_level (
  input  logic clk,
  input  logic rst_n,
  input  logic datain,
  output logic dataout
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], datain};
    end
  end

  assign dataout = sync_q[2];

endmodule

// File: rtl/gtfwizard_mac_example_gtfmac_hwchk_bitslip_ctrl.sv
// Supervisory sequencer: resets the bitslip adjuster, requests correction,
// qualifies block lock stability and re-acquires on failure or lock loss.
module gtfwizard_mac_example_gtfmac_hwchk_bitslip_ctrl
  import gtfmac_hwchk_bitslip_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned DONE_TIMEOUT = 4096,
  parameter int unsigned HOLD_CYCLES  = 1024,
  parameter int unsigned LOSS_FILTER  = 8,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic                  ctl_enable,
  input  logic                  ctl_rx_data_rate,
  input  logic                  stat_locked,
  input  logic                  stat_done,
  input  logic                  stat_excessive_bitslip,
  input  logic                  rx_block_lock,
  output logic                  bs_rst,
  output logic                  ctl_correct_bitslip,
  output logic [STATE_W-1:0]    stat_ctrl_state,
  output logic [RETRY_W-1:0]    stat_retry_cnt,
  output logic [LOSS_CNT_W-1:0] stat_lock_loss_cnt,
  output logic                  stat_link_up,
  output logic                  stat_fail
);

  localparam logic [TIMER_W-1:0] LD_RST   = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LD_LOCK  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LD_DONE  = TIMER_W'(DONE_TIMEOUT - 1);
  localparam logic [FILT_W-1:0]  HOLD_END = FILT_W'(HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0]  LOSS_END = FILT_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MX = RETRY_W'(MAX_RETRY);

  logic en_s;

  ctrl_state_e             state, state_nxt;
  logic [TIMER_W-1:0]      timer, timer_nxt;
  logic [FILT_W-1:0]       hold_cnt, hold_nxt;
  logic [FILT_W-1:0]       loss_cnt, loss_nxt;
  logic [RETRY_W-1:0]      retry_nxt;
  logic [LOSS_CNT_W-1:0]   lloss_nxt;
  logic                    rate_q, rate_nxt;
  logic                    fail_evt;

  example_gtfmac_hwchk_bitlip_syncer_level u_en_sync (
    .clk     (rx_clk),
    .rst_n   (rx_rst_n),
    .datain  (ctl_enable),
    .dataout (en_s)
  );

  function automatic logic [TIMER_W-1:0] timer_load(input ctrl_state_e s);
    case (s)
      RESET_BS:          timer_load = LD_RST;
      WAIT_LOCK, VERIFY: timer_load = LD_LOCK;
      CORRECT:           timer_load = LD_DONE;
      default:           timer_load = '0;
    endcase
  endfunction

  // Next-state, counter and failure evaluation
  always_comb begin
    state_nxt = state;
    timer_nxt = (timer != '0) ? timer - TIMER_W'(1) : timer;
    hold_nxt  = hold_cnt;
    loss_nxt  = loss_cnt;
    retry_nxt = stat_retry_cnt;
    lloss_nxt = stat_lock_loss_cnt;
    rate_nxt  = rate_q;
    fail_evt  = 1'b0;

    case (state)
      IDLE: begin
        if (en_s) state_nxt = RESET_BS;
      end
      RESET_BS: begin
        if (timer == '0) begin
          rate_nxt  = ctl_rx_data_rate;
          state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (stat_excessive_bitslip) fail_evt = 1'b1;
        else if (stat_locked)       state_nxt = rate_q ? VERIFY : CORRECT;
        else if (timer == '0)       fail_evt = 1'b1;
      end
      CORRECT: begin
        if (stat_excessive_bitslip) fail_evt = 1'b1;
        else if (stat_done)         state_nxt = VERIFY;
        else if (timer == '0)       fail_evt = 1'b1;
      end
      VERIFY: begin
        if (rx_block_lock && (hold_cnt == HOLD_END)) begin
          state_nxt = LINK_UP;
        end else begin
          hold_nxt = rx_block_lock ? hold_cnt + FILT_W'(1) : '0;
          if (timer == '0) fail_evt = 1'b1;
        end
      end
      LINK_UP: begin
        if (rx_block_lock) begin
          loss_nxt = '0;
        end else if (loss_cnt == LOSS_END) begin
          if (!(&stat_lock_loss_cnt)) lloss_nxt = stat_lock_loss_cnt + LOSS_CNT_W'(1);
          state_nxt = RESET_BS;
        end else begin
          loss_nxt = loss_cnt + FILT_W'(1);
        end
      end
      default: ;
    endcase

    if (fail_evt) begin
      if (stat_retry_cnt == RETRY_MX) begin
        state_nxt = FAIL;
      end else begin
        retry_nxt = stat_retry_cnt + RETRY_W'(1);
        state_nxt = RESET_BS;
      end
    end

    if (state_nxt == LINK_UP) retry_nxt = '0;

    // Disable overrides everything else in the cycle
    if (!en_s) begin
      state_nxt = IDLE;
      retry_nxt = '0;
      lloss_nxt = stat_lock_loss_cnt;
    end

    if (state_nxt != state) begin
      timer_nxt = timer_load(state_nxt);
      hold_nxt  = '0;
      loss_nxt  = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state               <= IDLE;
      timer               <= '0;
      hold_cnt            <= '0;
      loss_cnt            <= '0;
      rate_q              <= 1'b0;
      stat_retry_cnt      <= '0;
      stat_lock_loss_cnt  <= '0;
      bs_rst              <= 1'b1;
      ctl_correct_bitslip <= 1'b0;
      stat_link_up        <= 1'b0;
      stat_fail           <= 1'b0;
    end else begin
      state               <= state_nxt;
      timer               <= timer_nxt;
      hold_cnt            <= hold_nxt;
      loss_cnt            <= loss_nxt;
      rate_q              <= rate_nxt;
      stat_retry_cnt      <= retry_nxt;
      stat_lock_loss_cnt  <= lloss_nxt;
      bs_rst              <= (state_nxt == IDLE) || (state_nxt == RESET_BS) || (state_nxt == FAIL);
      ctl_correct_bitslip <= (state_nxt == CORRECT);
      stat_link_up        <= (state_nxt == LINK_UP);
      stat_fail           <= (state_nxt == FAIL);
    end
  end

  assign stat_ctrl_state = STATE_W'(state);

endmodule
